// File: rtl/aes_ctrl_wb_if.sv
// aes_ctrl_wb_if: Wishbone B4 pipelined bus between the data-bus decoder and the AES control slave.
interface aes_ctrl_wb_if;
    logic        wb_cyc_i;
    logic        wb_stb_i;
    logic        wb_we_i;
    logic [31:0] wb_adr_i;
    logic [31:0] wb_dat_i;
    logic [3:0]  wb_sel_i;
    logic        wb_ack_o;
    logic        wb_err_o;
    logic        wb_stall_o;
    logic [31:0] wb_dat_o;
    modport master (
        output wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_dat_i, wb_sel_i,
        input  wb_ack_o, wb_err_o, wb_stall_o, wb_dat_o
    );
    modport slave (
        input  wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_dat_i, wb_sel_i,
        output wb_ack_o, wb_err_o, wb_stall_o, wb_dat_o
    );
endinterface

// File: rtl/aes_ctrl_wb.sv
// aes_ctrl_wb: Wishbone slave holding AES plaintext/result, start pulse, ready tracking with timeout and IRQ.
module aes_ctrl_wb #(
    parameter logic [31:0] BASE_ADR       = 32'h1000_8030,
    parameter int          TIMEOUT_CYCLES = 4096
) (
    input  logic           wb_clk_i,
    input  logic           wb_rst_i,
    aes_ctrl_wb_if.slave   wb,
    output logic           aes_start_o,
    output logic [127:0]   aes_in_o,
    input  logic [127:0]   aes_out_i,
    input  logic           aes_ready_i,
    output logic           irq_o
);
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    typedef enum logic [1:0] {IDLE, FIRE, WAIT_LO, WAIT_HI} state_t;
    state_t              r_state, w_state_nxt;
    logic [3:0][31:0]    r_in, r_out;
    logic [CW-1:0]       r_cnt;
    logic                r_irq_en, r_done, r_to, r_ack, r_err;
    logic [31:0]         r_dat, w_off, w_rdat, w_mask;
    logic [3:0]          w_idx;
    logic                w_req, w_wr, w_map, w_bad, w_busy, w_cnt_hit;
    logic                w_in_wr, w_ctrl_wr, w_stat_wr, w_done_set, w_to_set;

    assign w_off     = wb.wb_adr_i - BASE_ADR;
    assign w_idx     = w_off[5:2];
    assign w_req     = wb.wb_cyc_i & wb.wb_stb_i;
    assign w_wr      = w_req & wb.wb_we_i;
    assign w_map     = (w_off[1:0] == 2'b00) && (w_off[31:6] == '0) && (w_idx <= 4'd9);
    // IN writes are refused mid-operation so the core input stays stable
    assign w_bad     = !w_map || (wb.wb_we_i && ((w_idx <= 4'd3 && w_busy) || w_idx >= 4'd6));
    assign w_in_wr   = w_wr && !w_bad && (w_idx <= 4'd3);
    assign w_ctrl_wr = w_wr && !w_bad && (w_idx == 4'd4) && wb.wb_sel_i[0];
    assign w_stat_wr = w_wr && !w_bad && (w_idx == 4'd5) && wb.wb_sel_i[0];
    assign w_mask    = {{8{wb.wb_sel_i[3]}}, {8{wb.wb_sel_i[2]}}, {8{wb.wb_sel_i[1]}}, {8{wb.wb_sel_i[0]}}};
    assign w_cnt_hit = r_cnt == CW'(TIMEOUT_CYCLES - 1);
    assign w_rdat    = (w_idx <= 4'd3) ? r_in[w_idx[1:0]] :
                       (w_idx == 4'd4) ? {30'd0, r_irq_en, 1'b0} :
                       (w_idx == 4'd5) ? {29'd0, r_to, r_done, w_busy} : r_out[w_idx[1:0] - 2'd2];

    assign wb.wb_ack_o   = r_ack;
    assign wb.wb_err_o   = r_err;
    assign wb.wb_dat_o   = r_dat;
    assign wb.wb_stall_o = 1'b0;
    assign aes_in_o      = r_in;
    assign irq_o         = r_done & r_irq_en;

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) r_state <= IDLE;
        else          r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_ctrl_wr && wb.wb_dat_i[0]) w_state_nxt = FIRE;
            FIRE:    w_state_nxt = WAIT_LO;
            WAIT_LO: if (w_cnt_hit) w_state_nxt = IDLE; else if (!aes_ready_i) w_state_nxt = WAIT_HI;
            WAIT_HI: if (aes_ready_i || w_cnt_hit) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        aes_start_o = r_state == FIRE;
        w_busy      = r_state != IDLE;
        w_done_set  = r_state == WAIT_HI && aes_ready_i;
        w_to_set    = w_cnt_hit && (r_state == WAIT_LO || (r_state == WAIT_HI && !aes_ready_i));
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) r_cnt <= '0;
        else          r_cnt <= (r_state == FIRE) ? '0 : (w_busy ? r_cnt + CW'(1) : r_cnt);
    end

    // W1C clears lose against a same-cycle set
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            r_in     <= '0;
            r_out    <= '0;
            r_irq_en <= 1'b0;
            r_done   <= 1'b0;
            r_to     <= 1'b0;
            r_ack    <= 1'b0;
            r_err    <= 1'b0;
            r_dat    <= '0;
        end else begin
            r_ack  <= w_req && !w_bad;
            r_err  <= w_req && w_bad;
            r_dat  <= (w_req && !wb.wb_we_i && !w_bad) ? w_rdat : '0;
            if (w_in_wr) r_in[w_idx[1:0]] <= (r_in[w_idx[1:0]] & ~w_mask) | (wb.wb_dat_i & w_mask);
            if (w_ctrl_wr) r_irq_en <= wb.wb_dat_i[1];
            if (w_done_set) r_out <= aes_out_i;
            r_done <= w_done_set || (r_done && !(w_stat_wr && wb.wb_dat_i[1]));
            r_to   <= w_to_set || (r_to && !(w_stat_wr && wb.wb_dat_i[2]));
        end
    end
endmodule

// File: tb/tb_aes_ctrl_wb.sv
// tb_aes_ctrl_wb: directed bench for aes_ctrl_wb with a behavioural AES core and a short-timeout instance.
module tb_aes_ctrl_wb;
    localparam logic [31:0]  BASE    = 32'h1000_8030;
    localparam logic [127:0] AES_REF = {32'h70B4C55A, 32'hD8CDB780, 32'h6A7B0430, 32'h69C4E0D8};
    localparam logic [127:0] PT      = {32'hCCDDEEFF, 32'h8899AABB, 32'h44556677, 32'h00112233};
    localparam logic [127:0] STUCK   = {4{32'hA5A5_5A5A}};

    logic clk = 1'b0, rst = 1'b1;
    always #5 clk = ~clk;

    logic cyc = 1'b0, stb = 1'b0, we = 1'b0, use_to = 1'b0;
    logic [31:0] adr = '0, dat = '0;
    logic [3:0]  sel = '0;
    logic        start0, start1, irq0, irq1, ack, err;
    logic [127:0] in0, in1;
    logic [31:0] rdat;
    logic        rsp_ack, rsp_err;
    logic [31:0] rsp_dat;
    logic [127:0] core_out = '0;
    logic        core_ready = 1'b1;
    int          core_cnt = 0, starts0 = 0, n_chk = 0, n_err = 0;

    aes_ctrl_wb_if bus0();
    aes_ctrl_wb_if bus1();
    assign bus0.wb_cyc_i = cyc;
    assign bus0.wb_stb_i = stb & !use_to;
    assign bus0.wb_we_i  = we;
    assign bus0.wb_adr_i = adr;
    assign bus0.wb_dat_i = dat;
    assign bus0.wb_sel_i = sel;
    assign bus1.wb_cyc_i = cyc;
    assign bus1.wb_stb_i = stb & use_to;
    assign bus1.wb_we_i  = we;
    assign bus1.wb_adr_i = adr;
    assign bus1.wb_dat_i = dat;
    assign bus1.wb_sel_i = sel;
    assign ack  = use_to ? bus1.wb_ack_o : bus0.wb_ack_o;
    assign err  = use_to ? bus1.wb_err_o : bus0.wb_err_o;
    assign rdat = use_to ? bus1.wb_dat_o : bus0.wb_dat_o;

    aes_ctrl_wb dut (
        .wb_clk_i(clk), .wb_rst_i(rst), .wb(bus0),
        .aes_start_o(start0), .aes_in_o(in0), .aes_out_i(core_out),
        .aes_ready_i(core_ready), .irq_o(irq0)
    );

    aes_ctrl_wb #(.TIMEOUT_CYCLES(16)) dut_to (
        .wb_clk_i(clk), .wb_rst_i(rst), .wb(bus1),
        .aes_start_o(start1), .aes_in_o(in1), .aes_out_i(STUCK),
        .aes_ready_i(1'b1), .irq_o(irq1)
    );

    // core: ready drops the cycle after start, result appears 20 cycles later
    always @(posedge clk) begin
        if (start0) begin
            core_ready <= 1'b0;
            core_out   <= '1;
            core_cnt   <= 20;
        end else if (core_cnt == 1) begin
            core_ready <= 1'b1;
            core_out   <= AES_REF;
            core_cnt   <= 0;
        end else if (core_cnt > 0) core_cnt <= core_cnt - 1;
        if (start0) starts0 <= starts0 + 1;
    end

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic xfer(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = w; adr = a; dat = d; sel = s;
        @(negedge clk);
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        rsp_ack = ack; rsp_err = err; rsp_dat = rdat;
    endtask

    task automatic wr_ok(input string tag, input logic [31:0] off, input logic [31:0] d);
        xfer(1'b1, BASE + off, d, 4'hF);
        chk(tag, {rsp_ack, rsp_err}, 2'b10);
    endtask

    task automatic rd_chk(input string tag, input logic [31:0] off, input logic [31:0] exp);
        xfer(1'b0, BASE + off, 32'h0, 4'hF);
        chk(tag, {rsp_ack, rsp_err, rsp_dat}, {2'b10, exp});
    endtask

    task automatic err_chk(input string tag, input logic w, input logic [31:0] off, input logic [31:0] d);
        xfer(w, BASE + off, d, 4'hF);
        chk(tag, {rsp_ack, rsp_err, rsp_dat}, {2'b01, 32'h0});
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (n < 60) begin
            xfer(1'b0, BASE + 32'h14, 32'h0, 4'hF);
            if (rsp_ack && !rsp_dat[0]) break;
            n++;
        end
        chk(tag, n < 60, 1'b1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        chk("reset_outputs", {bus0.wb_ack_o, bus0.wb_err_o, bus0.wb_dat_o, start0, in0, irq0}, '0);
        rst = 1'b0;
        rd_chk("reset_status", 32'h14, 32'h0);
        rd_chk("reset_ctrl", 32'h10, 32'h0);

        wr_ok("wr_in0", 32'h00, 32'h00112233);
        wr_ok("wr_in1", 32'h04, 32'h44556677);
        wr_ok("wr_in2", 32'h08, 32'h8899AABB);
        wr_ok("wr_in3", 32'h0C, 32'hCCDDEEFF);
        wr_ok("wr_ctrl_start", 32'h10, 32'h3);
        chk("start_pulse_hi", {start0, in0}, {1'b1, PT});
        @(negedge clk);
        chk("start_pulse_lo", start0, 1'b0);
        wait_idle("enc1_done_wait");
        rd_chk("out0", 32'h18, 32'h69C4E0D8);
        rd_chk("out1", 32'h1C, 32'h6A7B0430);
        rd_chk("out2", 32'h20, 32'hD8CDB780);
        rd_chk("out3", 32'h24, 32'h70B4C55A);
        rd_chk("enc1_status", 32'h14, 32'h2);
        chk("enc1_irq", irq0, 1'b1);

        wr_ok("w1c_done", 32'h14, 32'h2);
        chk("irq_fall", irq0, 1'b0);
        rd_chk("status_cleared", 32'h14, 32'h0);

        wr_ok("start_masked", 32'h10, 32'h1);
        repeat (6) @(negedge clk);
        xfer(1'b1, BASE, 32'hDEADBEEF, 4'hF);
        chk("busy_in0_err", {rsp_ack, rsp_err}, 2'b01);
        wr_ok("busy_ctrl_ack", 32'h10, 32'h1);
        rd_chk("busy_status", 32'h14, 32'h1);
        rd_chk("busy_in0_kept", 32'h00, 32'h00112233);
        wait_idle("enc2_done_wait");
        rd_chk("enc2_status", 32'h14, 32'h2);
        chk("enc2_irq_masked", irq0, 1'b0);
        chk("start_count", starts0, 2);

        xfer(1'b1, BASE + 32'h04, 32'h0000AB00, 4'b0010);
        chk("be_wr_ack", {rsp_ack, rsp_err}, 2'b10);
        rd_chk("be_in1", 32'h04, 32'h4455AB77);
        err_chk("err_off28", 1'b0, 32'h28, 32'h0);
        err_chk("err_misalign", 1'b0, 32'h02, 32'h0);
        err_chk("err_wr_out0", 1'b1, 32'h18, 32'h12345678);
        rd_chk("out0_kept", 32'h18, 32'h69C4E0D8);

        use_to = 1'b1;
        rd_chk("to_out0_pre", 32'h18, 32'h0);
        wr_ok("to_start", 32'h10, 32'h1);
        cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = BASE + 32'h14;
        for (int k = 1; k <= 18; k++) begin
            @(negedge clk);
            if (k == 17) chk("to_busy_at_16", {ack, err, rdat}, {2'b10, 32'h1});
            if (k == 18) chk("to_set_at_17", {ack, err, rdat}, {2'b10, 32'h4});
        end
        cyc = 1'b0; stb = 1'b0;
        rd_chk("to_out0_post", 32'h18, 32'h0);
        rd_chk("to_out3_post", 32'h24, 32'h0);
        use_to = 1'b0;

        wr_ok("rst_start", 32'h10, 32'h3);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("rst_async_outputs", {start0, bus0.wb_ack_o, bus0.wb_err_o, bus0.wb_dat_o, in0, irq0}, '0);
        @(negedge clk);
        rst = 1'b0;
        rd_chk("rst_status", 32'h14, 32'h0);
        rd_chk("rst_out0", 32'h18, 32'h0);
        wr_ok("post_rst_start", 32'h10, 32'h3);
        wait_idle("post_rst_wait");
        rd_chk("post_rst_out0", 32'h18, 32'h69C4E0D8);
        rd_chk("post_rst_status", 32'h14, 32'h2);
        chk("post_rst_irq", irq0, 1'b1);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
